// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset controller.
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECUTER,
      EXECUTEI,
      ALUWB,
      BEQ,
      JAL
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ADD           = 3'b000;
   localparam logic [2:0] SUBTRACT      = 3'b001;
   localparam logic [2:0] AND           = 3'b010;
   localparam logic [2:0] OR            = 3'b011;
   localparam logic [2:0] SET_LESS_THAN = 3'b101;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] RES_ALUOUT   = 2'b00;
   localparam logic [1:0] RES_DATA     = 2'b01;
   localparam logic [1:0] RES_ALURES   = 2'b10;

   localparam logic [1:0] SRCA_PC      = 2'b00;
   localparam logic [1:0] SRCA_OLDPC   = 2'b01;
   localparam logic [1:0] SRCA_REGA    = 2'b10;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_IMM     = 2'b01;
   localparam logic [1:0] SRCB_FOUR    = 2'b10;

   localparam logic       ADR_PC       = 1'b0;
   localparam logic       ADR_ALUOUT   = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode into the 3-bit ALU control code.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic       op5_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o
);

   always_comb begin
      alu_control_o = ADD;
      unique case (aluop_i)
         ALUOP_SUB: alu_control_o = SUBTRACT;
         ALUOP_FUNCT: begin
            unique case (funct3_i)
               // op5 separates R-type from I-type so addi never becomes sub
               3'b000:  alu_control_o = (op5_i & funct7b5_i) ? SUBTRACT : ADD;
               3'b010:  alu_control_o = SET_LESS_THAN;
               3'b110:  alu_control_o = OR;
               3'b111:  alu_control_o = AND;
               default: alu_control_o = ADD;
            endcase
         end
         default: alu_control_o = ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle controller: sequences fetch/decode/execute/memory/writeback.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALU_control,
   output logic       illegal_instr
);

   state_t     state_q, state_d;
   logic [1:0] aluop;
   logic       mem_rdy;

   assign mem_rdy = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      PCWrite       = 1'b0;
      AdrSrc        = ADR_PC;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      ResultSrc     = RES_ALUOUT;
      ALUSrcA       = SRCA_PC;
      ALUSrcB       = SRCB_REGB;
      aluop         = ALUOP_ADD;
      illegal_instr = 1'b0;
      unique case (state_q)
         FETCH: begin
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            IRWrite   = mem_rdy;
            PCWrite   = mem_rdy;
            if (mem_rdy) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            unique case (opcode)
               OP_LOAD, OP_STORE: state_d = MEMADR;
               OP_RTYPE:          state_d = EXECUTER;
               OP_ITYPE:          state_d = EXECUTEI;
               OP_BRANCH:         state_d = BEQ;
               OP_JAL:            state_d = JAL;
               default: begin
                  state_d       = FETCH;
                  illegal_instr = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            state_d = opcode[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = ADR_ALUOUT;
            if (mem_rdy) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc   = ADR_ALUOUT;
            MemWrite = 1'b1;
            if (mem_rdy) state_d = FETCH;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_REGB;
            aluop   = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            aluop   = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         BEQ: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_REGB;
            aluop   = ALUOP_SUB;
            PCWrite = Zero;
            state_d = FETCH;
         end
         JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            PCWrite = 1'b1;
            state_d = ALUWB;
         end
         default: state_d = FETCH;
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop_i       (aluop),
      .funct3_i      (funct3),
      .op5_i         (opcode[5]),
      .funct7b5_i    (funct7b5),
      .alu_control_o (ALU_control)
   );

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main controller for the multicycle RV32I-subset core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath muxes, the register/memory write enables and the 3-bit ALU_control code into the ALU directly downstream, and it consumes the ALU Zero flag for branches. Supported instructions: lw, sw, R-type (add/sub/slt/or/and), I-type ALU (addi/slti/ori/andi), beq, jal.

Parameters:
MEM_WAIT_EN, 1, when 1 FETCH/MEMREAD/MEMWRITE stall until mem_ready; when 0 mem_ready is ignored and treated as 1

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  synchronous active-low reset
opcode  input  7  instruction register bits [6:0]
funct3  input  3  instruction register bits [14:12]
funct7b5  input  1  instruction register bit 30
Zero  input  1  ALU result == 0
mem_ready  input  1  memory access completes this cycle
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register/OldPC load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALU_result
ALUSrcA  output  2  00=PC, 01=OldPC, 10=register A
ALUSrcB  output  2  00=register B, 01=ImmExt, 10=constant 4
ALU_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  output  1  one-cycle pulse in DECODE for an unsupported opcode

Behaviour:
- Reset: with rst_n=0 at a rising edge, the state becomes FETCH. This applies mid-instruction, and any pending memory wait is abandoned. All outputs are then the FETCH values for the current mem_ready.
- Internal ALUOp: 00=add, 01=sub, 10=decode funct. All other outputs are Moore functions of the state. Exceptions: the PCWrite/IRWrite gating by mem_ready, and the BEQ PCWrite term, which uses Zero.
- Outputs are 0 unless listed for the state.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH with illegal_instr=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then goes to FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. MemWrite is held high until mem_ready, then the state goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero. Then goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then goes to ALUWB.
- ALU decode for ALUOp=10, by funct3:
  - 000 -> sub if (opcode[5] & funct7b5), else add; so addi never decodes as sub
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - any other funct3 -> add (no illegal flag)
- Latency with mem_ready tied to 1: lw 5 cycles, sw/R/I/jal 4 cycles, beq 3 cycles.
- Memory wait: each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  - opcode localparams
  - ALU_control codes (ADD, SUBTRACT, AND, OR, SET_LESS_THAN) with the encodings listed under Ports
  - mux-select localparams
- One sub-module, alu_decoder: purely combinational; maps ALUOp, funct3, opcode[5] and funct7b5 to ALU_control.

Test Plan:
1. Reset then add (opcode 0110011, funct3 000, funct7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALU_control=000 in EXECUTER; RegWrite=1 only in ALUWB.
2. sub (funct7b5=1) and addi (opcode 0010011, funct7b5=1) -> ALU_control 001 for sub, 000 for addi. slti -> 101; ori -> 011; andi -> 010.
3. lw with mem_ready low for 2 cycles in MEMREAD -> MEMREAD is held 3 cycles with AdrSrc=1, total 7 cycles; RegWrite with ResultSrc=01 for exactly one cycle.
4. beq in BEQ state: Zero=1 -> PCWrite=1 and ALU_control=001; Zero=0 -> PCWrite=0; both return to FETCH.
5. Opcode 1111111 -> illegal_instr=1 for one cycle in DECODE, next state FETCH, no write strobes asserted.
6. rst_n=0 asserted in MEMWRITE -> next state FETCH, MemWrite=0; FETCH with mem_ready=0 keeps IRWrite=0 and PCWrite=0.
